// File: rtl/mem_pkg.sv
// Shared types and helpers for the data-memory responder and its storage.
package mem_pkg;

  // Access sequencing: accept in IDLE, count wait states in WAIT, complete in RESP.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Latched operation kind.
  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

  localparam int WORD_BYTES = 4;
  localparam int ADDR_LSB   = $clog2(WORD_BYTES);

  // True when the byte-offset bits select the start of a word.
  function automatic logic is_aligned(input logic [ADDR_LSB-1:0] byte_off);
    return byte_off == '0;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage: synchronous write, registered read with a synchronous clear
// so the read register can present zero for faulting completions.
module dmem_array #(
  parameter int DATA_W      = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en_i,
  input  logic              rd_en_i,
  input  logic              rd_clr_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH_WORDS];
  logic [DATA_W-1:0] rdata_q;

  // Storage is not reset; contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[idx_i] <= wdata_i;
  end

  // Read register holds its value until the next read or error completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        rdata_q <= '0;
    else if (rd_en_i)  rdata_q <= mem_q[idx_i];
    else if (rd_clr_i) rdata_q <= '0;
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder: one access at a time, WAIT_CYCLES wait
// states, pipeline stall while busy, one-cycle completion pulse.
//
// Handshake: a request (mem_read|mem_write) seen in IDLE is accepted on that
// edge; the requester holds it stable while mem_stall=1. rdata_valid pulses for
// exactly one cycle (RESP) with mem_stall=0, so the pipeline advances on that
// edge. The request still visible during RESP is the completing one and is not
// re-accepted; a request present in the following cycle is a new access.
module dmem_responder
  import mem_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              addr_err,
  output logic              mem_stall,
  output logic [1:0]        dbg_state
);

  localparam int                IDX_W   = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_W-3:0] DEPTH_L = (ADDR_W - 2)'(DEPTH_WORDS);
  localparam logic [3:0]        WAIT_L  = 4'(WAIT_CYCLES);

  state_t            state_q;
  logic [3:0]        cnt_q;
  op_t               op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              rdata_valid_q;
  logic              addr_err_q;

  logic              req;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_wdata;
  op_t               cur_op;
  logic              cur_err;
  logic              fire;
  logic              wr_en;
  logic              rd_en;
  logic              rd_clr;

  // Select the access operands (live inputs when completing straight from IDLE,
  // latched copy otherwise) and decide whether the access happens on this edge.
  always_comb begin
    req       = mem_read | mem_write;
    cur_addr  = addr_q;
    cur_wdata = wdata_q;
    cur_op    = op_q;
    if (state_q == IDLE) begin
      cur_addr  = addr;
      cur_wdata = wdata;
      cur_op    = mem_write ? OP_WR : OP_RD;
    end
    cur_err = !is_aligned(cur_addr[ADDR_LSB-1:0]) ||
              (cur_addr[ADDR_W-1:ADDR_LSB] >= DEPTH_L);
    fire = 1'b0;
    if (state_q == IDLE && req && WAIT_CYCLES == 0) fire = 1'b1;
    if (state_q == WAIT && cnt_q <= 4'd1)           fire = 1'b1;
    wr_en     = fire && (cur_op == OP_WR) && !cur_err;
    rd_en     = fire && (cur_op == OP_RD) && !cur_err;
    rd_clr    = fire && cur_err;
    mem_stall = reset && (((state_q == IDLE) && req) || (state_q == WAIT));
  end

  // Access FSM with wait-state counter and registered completion flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      op_q          <= OP_RD;
      addr_q        <= '0;
      wdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      addr_err_q    <= 1'b0;
    end else begin
      rdata_valid_q <= fire;
      addr_err_q    <= fire && cur_err;
      case (state_q)
        IDLE: begin
          if (req) begin
            addr_q  <= addr;
            wdata_q <= wdata;
            op_q    <= mem_write ? OP_WR : OP_RD;
            cnt_q   <= WAIT_L;
            state_q <= (WAIT_CYCLES == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
          if (fire) state_q <= RESP;
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  dmem_array #(
    .DATA_W      (DATA_W),
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk      (clk),
    .rst_n    (reset),
    .wr_en_i  (wr_en),
    .rd_en_i  (rd_en),
    .rd_clr_i (rd_clr),
    .idx_i    (cur_addr[IDX_W+ADDR_LSB-1:ADDR_LSB]),
    .wdata_i  (cur_wdata),
    .rdata_o  (rdata)
  );

  assign rdata_valid = rdata_valid_q;
  assign addr_err    = addr_err_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (WAIT_CYCLES 2, 0, 3) share reset;
// directed accesses push expected completions into a queue that a monitor
// drains whenever any instance pulses rdata_valid.
module tb_dmem_responder;

  localparam int NDUT = 3;
  localparam int WC [NDUT] = '{2, 0, 3};
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic        clk;
  logic        reset;
  logic        mem_read    [NDUT];
  logic        mem_write   [NDUT];
  logic [31:0] addr        [NDUT];
  logic [31:0] wdata       [NDUT];
  logic [31:0] rdata       [NDUT];
  logic        rdata_valid [NDUT];
  logic        addr_err    [NDUT];
  logic        mem_stall   [NDUT];
  logic [1:0]  dbg_state   [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    dmem_responder #(
      .DATA_W      (32),
      .ADDR_W      (32),
      .DEPTH_WORDS (256),
      .WAIT_CYCLES (WC[g])
    ) u_dut (
      .clk         (clk),
      .reset       (reset),
      .mem_read    (mem_read[g]),
      .mem_write   (mem_write[g]),
      .addr        (addr[g]),
      .wdata       (wdata[g]),
      .rdata       (rdata[g]),
      .rdata_valid (rdata_valid[g]),
      .addr_err    (addr_err[g]),
      .mem_stall   (mem_stall[g]),
      .dbg_state   (dbg_state[g])
    );
  end

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  // entry: [63:62] dut, [61:46] cycle, [45] err, [44] check data, [31:0] data
  logic [63:0] exp_q [$];
  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] mk_exp(input int g, input int c, input logic err,
                                         input logic chk_d, input logic [31:0] d);
    logic [63:0] e;
    e = '0;
    e[63:62] = 2'(g);
    e[61:46] = 16'(c);
    e[45]    = err;
    e[44]    = chk_d;
    e[31:0]  = d;
    return e;
  endfunction

  // Monitor: every completion pulse must match the oldest expectation.
  always @(negedge clk) begin
    for (int g = 0; g < NDUT; g++) begin
      if (rdata_valid[g] === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_total++;
          n_bad++;
          $display("FAIL unexpected_valid: got pulse on dut %0d at cycle %0d required none", g, cyc);
        end else begin
          logic [63:0] e;
          e = exp_q.pop_front();
          chk("resp_dut",   64'(g),        64'(e[63:62]));
          chk("resp_cycle", 64'(cyc),      64'(e[61:46]));
          chk("resp_err",   64'(addr_err[g]), 64'(e[45]));
          if (e[44]) chk("resp_rdata", 64'(rdata[g]), 64'(e[31:0]));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_all();
    for (int g = 0; g < NDUT; g++) begin
      mem_read[g]  = 1'b0;
      mem_write[g] = 1'b0;
      addr[g]      = '0;
      wdata[g]     = '0;
    end
  endtask

  // One access held until the edge that ends RESP; checks stall timing inline.
  task automatic access(input int g, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic exp_err, input logic chk_d, input logic [31:0] exp_d);
    int c0;
    @(posedge clk); #1;
    mem_read[g] = rd; mem_write[g] = wr; addr[g] = a; wdata[g] = d;
    c0 = cyc;
    exp_q.push_back(mk_exp(g, c0 + WC[g] + 1, exp_err, chk_d, exp_d));
    for (int i = 0; i <= WC[g]; i++) begin
      @(negedge clk);
      chk("stall_busy", 64'(mem_stall[g]), 64'd1);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("stall_resp", 64'(mem_stall[g]), 64'd0);
    chk("state_resp", 64'(dbg_state[g]), 64'(ST_RESP));
    @(posedge clk); #1;
    mem_read[g] = 1'b0; mem_write[g] = 1'b0;
    @(negedge clk);
    chk("stall_after", 64'(mem_stall[g]), 64'd0);
    chk("state_after", 64'(dbg_state[g]), 64'(ST_IDLE));
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int c0;
    idle_all();
    reset = 1'b0;
    #23;
    for (int g = 0; g < NDUT; g++) begin
      chk("rst_rdata", 64'(rdata[g]),       64'd0);
      chk("rst_valid", 64'(rdata_valid[g]), 64'd0);
      chk("rst_err",   64'(addr_err[g]),    64'd0);
      chk("rst_stall", 64'(mem_stall[g]),   64'd0);
      chk("rst_state", 64'(dbg_state[g]),   64'(ST_IDLE));
    end
    @(negedge clk);
    reset = 1'b1;
    wait_cycles(2);

    // WAIT_CYCLES=2: basic write/read, faults, write-wins
    access(0, 1'b0, 1'b1, 32'h10,  32'hDEADBEEF, 1'b0, 1'b0, 32'h0);
    access(0, 1'b1, 1'b0, 32'h10,  32'h0,        1'b0, 1'b1, 32'hDEADBEEF);
    access(0, 1'b0, 1'b1, 32'h0,   32'h0BADF00D, 1'b0, 1'b0, 32'h0);
    access(0, 1'b1, 1'b0, 32'h13,  32'h0,        1'b1, 1'b1, 32'h0);
    access(0, 1'b0, 1'b1, 32'h400, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h0);
    access(0, 1'b1, 1'b0, 32'h0,   32'h0,        1'b0, 1'b1, 32'h0BADF00D);
    access(0, 1'b1, 1'b1, 32'h20,  32'hA5A5A5A5, 1'b0, 1'b0, 32'h0);
    access(0, 1'b1, 1'b0, 32'h20,  32'h0,        1'b0, 1'b1, 32'hA5A5A5A5);
    wait_cycles(2);
    chk("rdata_hold", 64'(rdata[0]), 64'hA5A5A5A5);

    // WAIT_CYCLES=0
    access(1, 1'b0, 1'b1, 32'h0, 32'h12345678, 1'b0, 1'b0, 32'h0);
    access(1, 1'b1, 1'b0, 32'h0, 32'h0,        1'b0, 1'b1, 32'h12345678);

    // WAIT_CYCLES=3: read held across two completions
    access(2, 1'b0, 1'b1, 32'h40, 32'hCAFEF00D, 1'b0, 1'b0, 32'h0);
    @(posedge clk); #1;
    mem_read[2] = 1'b1; addr[2] = 32'h40;
    c0 = cyc;
    exp_q.push_back(mk_exp(2, c0 + 4, 1'b0, 1'b1, 32'hCAFEF00D));
    exp_q.push_back(mk_exp(2, c0 + 9, 1'b0, 1'b1, 32'hCAFEF00D));
    wait_cycles(6);
    mem_read[2] = 1'b0;
    wait_cycles(6);
    chk("b2b_drained", 64'(exp_q.size()), 64'd0);

    // Reset during WAIT discards the pending write
    access(0, 1'b0, 1'b1, 32'h20, 32'h11111111, 1'b0, 1'b0, 32'h0);
    @(posedge clk); #1;
    mem_write[0] = 1'b1; addr[0] = 32'h20; wdata[0] = 32'h22222222;
    @(posedge clk); #1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("arst_state", 64'(dbg_state[0]),   64'(ST_IDLE));
    chk("arst_stall", 64'(mem_stall[0]),   64'd0);
    chk("arst_valid", 64'(rdata_valid[0]), 64'd0);
    @(posedge clk); #1;
    mem_write[0] = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    wait_cycles(5);
    access(0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b1, 32'h11111111);

    wait_cycles(5);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
